// File: rtl/leb128_stream_u64.sv
// Byte-serial LEB128 unsigned decoder.
// Collects 7-bit chunks from a valid/ready byte stream, least significant chunk
// first. A value ends on a byte with bit 7 clear, or on the MAXB-th byte. The
// decoded value, its encoded length and an error flag appear on a registered
// valid/ready output one cycle after that byte is accepted.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holds its payload stable while valid is high and ready is low.
// in_ready depends combinationally on out_ready, so a blocked output can be
// consumed and reloaded on the same edge.
module leb128_stream_u64 #(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic [3:0]   out_len,
   output logic         out_err,
   output logic         out_valid,
   input  logic         out_ready
);

   localparam int         MAXB = (W + 6) / 7;
   localparam logic [3:0] LAST = 4'(MAXB - 1);

   // ACC collects a value. DISC drops the continuation tail that follows a
   // value which was cut off at MAXB bytes.
   localparam logic [0:0] ST_ACC  = 1'b0;
   localparam logic [0:0] ST_DISC = 1'b1;

   logic [0:0]   state;
   logic [3:0]   cnt;
   logic [W-1:0] acc;

   logic [6:0]   shamt;
   logic [W+6:0] chunk_wide;
   logic [W-1:0] chunk;
   logic         dropped;
   logic         accept;
   logic         last_byte;
   logic         term;

   // Place the incoming chunk at its bit position. Bits that land at or above W
   // are kept apart so the last byte can flag an overflow.
   always_comb begin
      shamt      = 7'(cnt) * 7'd7;
      chunk_wide = {{W{1'b0}}, in_data[6:0]} << shamt;
      chunk      = chunk_wide[W-1:0];
      dropped    = |chunk_wide[W+6:W];
   end

   // Input readiness and the byte-level decode of the current transfer.
   always_comb begin
      in_ready  = (state == ST_DISC) ? 1'b1 : (!out_valid || out_ready);
      accept    = in_valid && in_ready;
      last_byte = (cnt == LAST);
      term      = accept && (state == ST_ACC) && (!in_data[7] || last_byte);
   end

   // Accumulator, byte counter, tail-discard state and the registered output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_ACC;
         cnt       <= 4'd0;
         acc       <= '0;
         out_data  <= '0;
         out_len   <= 4'd0;
         out_err   <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         // A consumed output drops unless a new value lands on the same edge.
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (accept) begin
            if (state == ST_DISC) begin
               // Tail bytes are dropped; the first byte without continuation
               // ends the tail and the next byte starts a new value.
               if (!in_data[7]) begin
                  state <= ST_ACC;
               end
            end else if (term) begin
               out_data  <= acc | chunk;
               out_len   <= cnt + 4'd1;
               out_err   <= last_byte && (in_data[7] || dropped);
               out_valid <= 1'b1;
               acc       <= '0;
               cnt       <= 4'd0;
               if (last_byte && in_data[7]) begin
                  state <= ST_DISC;
               end
            end else begin
               acc <= acc | chunk;
               cnt <= cnt + 4'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_leb128_stream_u64.sv
// Testbench for leb128_stream_u64: directed cases with literal results,
// followed by randomized traffic with backpressure and occasional resets.
// A value-level model sits beside the DUT and is compared on every cycle.
module tb_leb128_stream_u64;

   localparam int W    = 64;
   localparam int MAXB = 10;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   in_data;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] out_data;
   logic [3:0]   out_len;
   logic         out_err;
   logic         out_valid;
   logic         out_ready;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [63:0] d;
      logic [3:0]  l;
      logic        e;
   } out_t;

   // Completed output transfers, in order, for the literal checks.
   out_t out_log[$];

   // Model state: bytes of the value in progress and the expected output.
   logic [7:0]   cur_q[$];
   logic         m_valid;
   logic [63:0]  m_data;
   logic [3:0]   m_len;
   logic         m_err;
   logic         m_disc;
   logic         exp_rdy;
   logic         nv;
   logic [127:0] v;
   int           long_left = 0;

   leb128_stream_u64 #(.W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_len   (out_len),
      .out_err   (out_err),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Model: decode the whole value from its bytes with plain wide arithmetic.
   // Compare at each falling edge, then advance to the state after the next
   // rising edge.
   always @(negedge clk) begin
      if (rst) begin
         cur_q.delete();
         m_valid = 1'b0;
         m_data  = '0;
         m_len   = '0;
         m_err   = 1'b0;
         m_disc  = 1'b0;
         chk("reset out_valid", 64'(out_valid), 64'(0));
         chk("reset out_data", out_data, 64'(0));
         chk("reset out_len", 64'(out_len), 64'(0));
         chk("reset out_err", 64'(out_err), 64'(0));
      end else begin
         exp_rdy = m_disc ? 1'b1 : (!m_valid || out_ready);
         chk("in_ready", 64'(in_ready), 64'(exp_rdy));
         chk("out_valid", 64'(out_valid), 64'(m_valid));
         if (m_valid) begin
            chk("out_data", out_data, m_data);
            chk("out_len", 64'(out_len), 64'(m_len));
            chk("out_err", 64'(out_err), 64'(m_err));
            if (out_ready) out_log.push_back({out_data, out_len, out_err});
         end
         nv = m_valid && !out_ready;
         if (in_valid && exp_rdy) begin
            if (m_disc) begin
               if (!in_data[7]) m_disc = 1'b0;
            end else begin
               cur_q.push_back(in_data);
               if (!in_data[7] || cur_q.size() == MAXB) begin
                  v = '0;
                  foreach (cur_q[i]) v = v | (128'(cur_q[i][6:0]) << (7 * i));
                  m_data = v[63:0];
                  m_len  = 4'(cur_q.size());
                  m_err  = (cur_q.size() == MAXB) && (in_data[7] || (v[127:64] != 0));
                  m_disc = (cur_q.size() == MAXB) && in_data[7];
                  nv     = 1'b1;
                  cur_q.delete();
               end
            end
         end
         m_valid = nv;
      end
   end

   // Driver: offer one byte and hold it until accepted (bounded wait).
   task automatic send(input logic [7:0] b);
      int   n = 0;
      logic took;
      in_valid = 1'b1;
      in_data  = b;
      do begin
         @(negedge clk);
         took = in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!took && n < 200);
      in_valid = 1'b0;
      if (!took) begin
         checks++;
         errors++;
         $display("FAIL send timeout: byte %h not accepted after %0d cycles", b, n);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_ff(input int n);
      repeat (n) send(8'hFF);
   endtask

   // Pop the oldest completed output and compare it to hand-computed values.
   task automatic check_out(input string name, input logic [63:0] d, input logic [3:0] l,
                            input logic e);
      out_t o;
      checks++;
      if (out_log.size() == 0) begin
         errors++;
         $display("FAIL %s: no output seen, expected data %h len %0d err %0d", name, d, l, e);
      end else begin
         o = out_log.pop_front();
         chk({name, " data"}, o.d, d);
         chk({name, " len"}, 64'(o.l), 64'(l));
         chk({name, " err"}, 64'(o.e), 64'(e));
      end
   endtask

   task automatic check_no_more(input string name);
      chk({name, " extra outputs"}, 64'(out_log.size()), 64'(0));
      out_log.delete();
   endtask

   initial begin
      logic acc_now;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      idle(2);
      rst = 1'b0;
      idle(1);

      // Three-byte value.
      send(8'hE5); send(8'h8E); send(8'h26);
      idle(3);
      check_out("t1", 64'd624485, 4'd3, 1'b0);
      check_no_more("t1");

      // Back-to-back single-byte values.
      send(8'h00); send(8'h7F); send(8'h01);
      idle(3);
      check_out("t2a", 64'd0, 4'd1, 1'b0);
      check_out("t2b", 64'd127, 4'd1, 1'b0);
      check_out("t2c", 64'd1, 4'd1, 1'b0);
      check_no_more("t2");

      // Ten-byte values at the width boundary.
      send_ff(9); send(8'h01);
      send_ff(9); send(8'h7F);
      send(8'h05);
      idle(3);
      check_out("t3 max", 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b0);
      check_out("t3 ovf", 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b1);
      check_out("t3 next", 64'd5, 4'd1, 1'b0);
      check_no_more("t3");

      // Overlong value, tail discarded.
      send_ff(10); send(8'h80); send(8'h05); send(8'h03);
      idle(3);
      check_out("t4 long", 64'hFFFF_FFFF_FFFF_FFFF, 4'd10, 1'b1);
      check_out("t4 after", 64'd3, 4'd1, 1'b0);
      check_no_more("t4");

      // Non-minimal encoding is legal.
      send(8'h80); send(8'h00);
      idle(3);
      check_out("nonmin", 64'd0, 4'd2, 1'b0);
      check_no_more("nonmin");

      // Output stall, then same-edge handoff.
      send(8'h05);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h06;
      idle(2);
      chk("stall in_ready", 64'(in_ready), 64'(0));
      chk("stall out_data", out_data, 64'd5);
      idle(3);
      out_ready = 1'b1;
      idle(1);
      in_valid = 1'b0;
      idle(3);
      check_out("t5 first", 64'd5, 4'd1, 1'b0);
      check_out("t5 second", 64'd6, 4'd1, 1'b0);
      check_no_more("t5");

      // Reset in the middle of a value.
      send(8'h81);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      send(8'h01);
      idle(3);
      check_out("t6", 64'd1, 4'd1, 1'b0);
      check_no_more("t6");

      // Randomized traffic; the model checks every cycle.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         acc_now = in_valid && in_ready && !rst;
         @(posedge clk);
         #1;
         rst       = ($urandom_range(0, 599) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         if (rst) begin
            in_valid = 1'b0;
         end else if (!in_valid || acc_now) begin
            in_valid = ($urandom_range(0, 3) != 0);
            if (long_left > 0) begin
               in_data = 8'hFF;
               long_left--;
            end else begin
               if ($urandom_range(0, 19) == 0) long_left = $urandom_range(8, 12);
               in_data = 8'($urandom_range(0, 255));
               if ($urandom_range(0, 9) < 4) in_data[7] = 1'b0;
            end
         end
      end
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      idle(5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
